mem_lsu: RTL
============

# mem_lsu

Memory-access stage of the five-stage pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register. Non-memory results pass straight through to MEM/WB. Loads and stores are performed over a single-outstanding, request/acknowledge data bus, with stallreq holding the pipeline until the access completes and its result is consumed.

## Interface
- (no parameters; widths come from the shared defines: RegBus = 32, RegAddrBus = 5, AluOpBus = 8)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stall  in  6  stall vector from the stall controller; bit 4 = MEM stage
- flush  in  1  exception flush; discard the in-flight memory op
- ex_aluop  in  8  operation code from EX/MEM
- ex_wd, ex_wreg, ex_wdata  in  5/1/32  destination register, write enable, ALU result
- ex_hi, ex_lo, ex_whilo  in  32/32/1  HI/LO result and its write enable
- ex_mem_addr  in  32  effective byte address
- ex_reg2  in  32  store data
- mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo  out  5/1/32/32/32/1  result to MEM/WB
- mem_misalign  out  1  misaligned access detected this cycle
- stallreq  out  1  request to stall stages 0–4
- bus_req  out  1  access request, held until acknowledged
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, low two bits 00
- bus_sel  out  4  byte lanes; bit 3 = bits 31:24
- bus_wdata  out  32  write data
- bus_ack  in  1  access complete
- bus_rdata  in  32  read data, valid when bus_ack = 1

## Operation
- Op codes, defined in the shared defines: LB E0, LBU E4, LH E1, LHU E5, LW E3, SB E8, SH E9, SW EB (hex). Every other code is a non-memory op.
- **Byte order is big-endian.**
  - Byte lanes: offset 00 → sel 1000, 01 → 0100, 10 → 0010, 11 → 0001.
  - Halfwords: addr[1] = 0 → sel 1100; addr[1] = 1 → sel 0011.
  - Word: sel 1111.
- **Store data.** The byte or halfword is replicated across all lanes: SB → {4{reg2[7:0]}}, SH → {2{reg2[15:0]}}.
- **Load data.**
  - The addressed lane is extracted from the read word.
  - LB and LH sign-extend; LBU and LHU zero-extend.
- **Misalignment.**
  - LH, LHU, SH with addr[0] = 1, or LW, SW with addr[1:0] ≠ 00, are misaligned.
  - A misaligned op produces mem_misalign = 1, mem_wreg = 0, no bus access and no stall.
- **Non-memory op.** Every mem_* output equals the corresponding ex_* input combinationally. stallreq = 0.
- mem_hi, mem_lo and mem_whilo always pass through from ex_hi, ex_lo and ex_whilo.
- **FSM states: IDLE, BUSY, DONE, ABORT.**
  - **IDLE.** On an aligned memory op with flush = 0:
    - register the bus outputs (bus_req = 1);
    - go to BUSY;
    - stallreq = 1; mem_wreg = 0; mem_whilo = 0.
  - **BUSY.**
    - Bus outputs are held stable and stallreq = 1.
    - On bus_ack: capture the load-aligned result in rd_buf, drop bus_req, go to DONE.
    - flush = 1 without bus_ack → go to ABORT.
    - flush = 1 together with bus_ack → go to IDLE, result discarded.
  - **DONE.**
    - stallreq = 0; mem_wdata = rd_buf for loads, ex_wdata for stores; mem_wreg = ex_wreg.
    - Go to IDLE when stall[4] = 0 (the result has been consumed).
    - flush = 1 → go to IDLE; mem_wreg is forced to 0.
  - **ABORT.**
    - bus_req stays held until bus_ack, because a bus access cannot be cancelled.
    - mem_wreg = 0.
    - stallreq = 1 only if ex_aluop is a new memory op.
    - On bus_ack → go to IDLE.
- **Flush in IDLE.** No access is issued.

## Timing
- **Reset values:**
  - state = IDLE; bus_req = 0; bus_we = 0; bus_sel = 0; bus_addr = 0; bus_wdata = 0; rd_buf = 0.
  - While rst = 1, all mem_* outputs are 0 / write-disable, and stallreq = 0 and mem_misalign = 0.
  - Reset mid-access drops bus_req on the next edge.
- **Load cycle by cycle:**
  - Op presented in cycle T.
  - bus_req = 1 from T+1.
  - Slave acks in cycle A ≥ T+1.
  - DONE in A+1.
  - MEM/WB captures at the end of A+1.
  - Zero-wait access: 3 cycles.
- No new request is issued in the cycle after DONE exits, because EX/MEM advances on that same edge.
- bus_ack is ignored in IDLE and DONE.

## Structure
- The op codes, Stop/NoStop and the Enable/Disable constants live in the shared defines file.
- One natural sub-module: mem_align. It is combinational and produces:
  - bus_sel and replicated store data from op and addr;
  - extracted, extended load data;
  - misalign detection.
- The FSM, bus registers and rd_buf stay in mem_lsu.

## Test plan
- **Pass-through.** ADD with ex_wd = 3, ex_wdata = 0x1234 → mem_wdata = 0x1234 in the same cycle; stallreq = 0; bus_req stays 0.
- **LB with wait states.** addr 0x101, ack after 2 wait cycles with rdata 0x11F23344 → bus_sel = 0100; stallreq high until ack; next cycle mem_wdata = 0xFFFFFFF2 and mem_wreg = 1.
- **Stores.**
  - SH at 0x102 with reg2 = 0xABCD → bus_we = 1, bus_sel = 0011, bus_wdata = 0xABCDABCD, bus_addr = 0x100.
  - SB at 0x103 with reg2 = 0x5A → bus_sel = 0001, bus_wdata = 0x5A5A5A5A.
- **Misaligned word.** LW at 0x102 → mem_misalign = 1, mem_wreg = 0, no bus_req, stallreq = 0.
- **External stall in DONE.** Hold stall[4] = 1 for 3 cycles → rd_buf result held, no second bus_req; then exit to IDLE.
- **Flush in BUSY.** Flush, ack 2 cycles later → bus_req held until ack; mem_wreg never asserted; a following LW issues only after ack. Also: rst pulse in BUSY → bus_req = 0 next cycle.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-access stage: bus widths, load/store op codes,
// stall/write-enable constants and the access FSM encoding.
package mem_lsu_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int AluOpBus   = 8;

  localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'hE0;
  localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'hE4;
  localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'hE1;
  localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'hE5;
  localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'hE3;
  localparam logic [AluOpBus-1:0] EXE_SB_OP  = 8'hE8;
  localparam logic [AluOpBus-1:0] EXE_SH_OP  = 8'hE9;
  localparam logic [AluOpBus-1:0] EXE_SW_OP  = 8'hEB;

  localparam logic Stop         = 1'b1;
  localparam logic NoStop       = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE,
    ST_ABORT
  } lsu_state_e;

endpackage

// File: rtl/mem_lsu_align.sv
// Big-endian lane steering for the memory stage: byte-lane selects, replicated
// store data, extracted/extended load data and misalignment detection.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [AluOpBus-1:0] aluop,
  input  logic [1:0]          addr_lo,
  input  logic [RegBus-1:0]   reg2,
  input  logic [RegBus-1:0]   rdata,
  output logic                is_load,
  output logic                is_store,
  output logic                misalign,
  output logic [3:0]          sel,
  output logic [RegBus-1:0]   st_wdata,
  output logic [RegBus-1:0]   ld_data
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [3:0]  byte_sel;
  logic [3:0]  half_sel;

  // Lowest byte address maps to the most significant lane.
  always_comb begin
    rd_byte = rdata[31:24];
    case (addr_lo)
      2'b00:   rd_byte = rdata[31:24];
      2'b01:   rd_byte = rdata[23:16];
      2'b10:   rd_byte = rdata[15:8];
      default: rd_byte = rdata[7:0];
    endcase
    rd_half  = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    byte_sel = 4'b1000 >> addr_lo;
    half_sel = addr_lo[1] ? 4'b0011 : 4'b1100;
  end

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    misalign = 1'b0;
    sel      = 4'b0000;
    st_wdata = reg2;
    ld_data  = '0;
    case (aluop)
      EXE_LB_OP: begin
        is_load = 1'b1;
        sel     = byte_sel;
        ld_data = {{24{rd_byte[7]}}, rd_byte};
      end
      EXE_LBU_OP: begin
        is_load = 1'b1;
        sel     = byte_sel;
        ld_data = {24'd0, rd_byte};
      end
      EXE_LH_OP: begin
        is_load  = 1'b1;
        sel      = half_sel;
        misalign = addr_lo[0];
        ld_data  = {{16{rd_half[15]}}, rd_half};
      end
      EXE_LHU_OP: begin
        is_load  = 1'b1;
        sel      = half_sel;
        misalign = addr_lo[0];
        ld_data  = {16'd0, rd_half};
      end
      EXE_LW_OP: begin
        is_load  = 1'b1;
        sel      = 4'b1111;
        misalign = |addr_lo;
        ld_data  = rdata;
      end
      EXE_SB_OP: begin
        is_store = 1'b1;
        sel      = byte_sel;
        st_wdata = {4{reg2[7:0]}};
      end
      EXE_SH_OP: begin
        is_store = 1'b1;
        sel      = half_sel;
        misalign = addr_lo[0];
        st_wdata = {2{reg2[15:0]}};
      end
      EXE_SW_OP: begin
        is_store = 1'b1;
        sel      = 4'b1111;
        misalign = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access pipeline stage: passes ALU results to MEM/WB and performs loads and
// stores over a single-outstanding request/acknowledge bus, stalling until done.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall,
  input  logic                  flush,
  input  logic [AluOpBus-1:0]   ex_aluop,
  input  logic [RegAddrBus-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [RegBus-1:0]     ex_wdata,
  input  logic [RegBus-1:0]     ex_hi,
  input  logic [RegBus-1:0]     ex_lo,
  input  logic                  ex_whilo,
  input  logic [RegBus-1:0]     ex_mem_addr,
  input  logic [RegBus-1:0]     ex_reg2,
  output logic [RegAddrBus-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [RegBus-1:0]     mem_wdata,
  output logic [RegBus-1:0]     mem_hi,
  output logic [RegBus-1:0]     mem_lo,
  output logic                  mem_whilo,
  output logic                  mem_misalign,
  output logic                  stallreq,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [RegBus-1:0]     bus_addr,
  output logic [3:0]            bus_sel,
  output logic [RegBus-1:0]     bus_wdata,
  input  logic                  bus_ack,
  input  logic [RegBus-1:0]     bus_rdata
);

  lsu_state_e        state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [RegBus-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_sel_q, bus_sel_d;
  logic [RegBus-1:0] bus_wdata_q, bus_wdata_d;
  logic [RegBus-1:0] rd_buf_q, rd_buf_d;

  logic              is_load, is_store, misalign;
  logic              mem_op, mem_go;
  logic [3:0]        sel;
  logic [RegBus-1:0] st_wdata, ld_data;
  logic              unused_stall;

  // Only the MEM-stage bit of the stall vector matters here.
  assign unused_stall = ^{stall[5], stall[3:0]};

  mem_lsu_align u_align (
    .aluop    (ex_aluop),
    .addr_lo  (ex_mem_addr[1:0]),
    .reg2     (ex_reg2),
    .rdata    (bus_rdata),
    .is_load  (is_load),
    .is_store (is_store),
    .misalign (misalign),
    .sel      (sel),
    .st_wdata (st_wdata),
    .ld_data  (ld_data)
  );

  assign mem_op = is_load | is_store;
  assign mem_go = mem_op & ~misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= 4'b0000;
      bus_wdata_q <= '0;
      rd_buf_q    <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      rd_buf_q    <= rd_buf_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_sel_d    = bus_sel_q;
    bus_wdata_d  = bus_wdata_q;
    rd_buf_d     = rd_buf_q;
    mem_wd       = ex_wd;
    mem_wreg     = ex_wreg;
    mem_wdata    = ex_wdata;
    mem_hi       = ex_hi;
    mem_lo       = ex_lo;
    mem_whilo    = ex_whilo;
    mem_misalign = misalign;
    stallreq     = NoStop;

    case (state_q)
      ST_IDLE: begin
        if (mem_op) mem_wreg = WriteDisable;
        if (mem_go && !flush) begin
          stallreq    = Stop;
          mem_whilo   = WriteDisable;
          bus_req_d   = 1'b1;
          bus_we_d    = is_store;
          bus_addr_d  = {ex_mem_addr[RegBus-1:2], 2'b00};
          bus_sel_d   = sel;
          bus_wdata_d = st_wdata;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stallreq  = Stop;
        mem_wreg  = WriteDisable;
        mem_whilo = WriteDisable;
        if (bus_ack) begin
          bus_req_d = 1'b0;
          rd_buf_d  = ld_data;
          state_d   = flush ? ST_IDLE : ST_DONE;
        end else if (flush) begin
          state_d = ST_ABORT;
        end
      end
      ST_DONE: begin
        mem_wreg = flush ? WriteDisable : ex_wreg;
        if (is_load) mem_wdata = rd_buf_q;
        if (flush || !stall[4]) state_d = ST_IDLE;
      end
      ST_ABORT: begin
        // The orphaned access must still complete before a new one may start.
        mem_wreg = WriteDisable;
        if (mem_go) stallreq = Stop;
        if (bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rst) begin
      mem_wd       = '0;
      mem_wreg     = WriteDisable;
      mem_wdata    = '0;
      mem_hi       = '0;
      mem_lo       = '0;
      mem_whilo    = WriteDisable;
      mem_misalign = 1'b0;
      stallreq     = NoStop;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_sel   = bus_sel_q;
  assign bus_wdata = bus_wdata_q;

endmodule
